// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shared state encoding and default geometry for the shifter BIST
package shifter_pkg;

  typedef enum logic [1:0] {
    st_idle  = 2'd0,
    st_shift = 2'd1,
    st_drain = 2'd2,
    st_done  = 2'd3
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_TAP1  = 3;
  localparam int DEF_TAP2  = 5;

endpackage

// File: rtl/shifter.sv
// rtl/shifter.sv - serial delay line with taps at TAP1 and TAP2 cycles
module shifter #(
  parameter int TAP1 = 3,
  parameter int TAP2 = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic data,
  output logic out1,
  output logic out2
);

  logic [TAP2-1:0] dly;

  always_ff @(posedge clk) begin
    if (rst) dly <= '0;
    else     dly <= {dly[TAP2-2:0], data};
  end

  assign out1 = dly[TAP1-1];
  assign out2 = dly[TAP2-1];

endmodule

// File: rtl/shifter_bist_top.sv
// rtl/shifter_bist_top.sv - integration of the shifter with its BIST controller
module shifter_bist_top
  import shifter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TAP1  = DEF_TAP1,
  parameter int TAP2  = DEF_TAP2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_word,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res1,
  output logic [WIDTH-1:0] res2,
  output logic             err,
  output logic [7:0]       err_cnt
);

  logic sh_data, sh_rst, sh_out1, sh_out2;

  shifter #(.TAP1(TAP1), .TAP2(TAP2)) u_shifter (
    .clk  (clk),
    .rst  (sh_rst),
    .data (sh_data),
    .out1 (sh_out1),
    .out2 (sh_out2)
  );

  shifter_bist_ctrl #(.WIDTH(WIDTH), .TAP1(TAP1), .TAP2(TAP2)) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_word   (in_word),
    .in_ready  (in_ready),
    .sh_data   (sh_data),
    .sh_rst    (sh_rst),
    .sh_out1   (sh_out1),
    .sh_out2   (sh_out2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res1      (res1),
    .res2      (res2),
    .err       (err),
    .err_cnt   (err_cnt)
  );

endmodule

// File: rtl/shifter_bist_ctrl.sv
// rtl/shifter_bist_ctrl.sv - serialises a test word through the shifter and checks both taps
module shifter_bist_ctrl
  import shifter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TAP1  = DEF_TAP1,
  parameter int TAP2  = DEF_TAP2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_word,
  output logic             in_ready,
  output logic             sh_data,
  output logic             sh_rst,
  input  logic             sh_out1,
  input  logic             sh_out2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res1,
  output logic [WIDTH-1:0] res2,
  output logic             err,
  output logic [7:0]       err_cnt
);

  localparam int CW   = $clog2(WIDTH + TAP2 + 1);
  localparam int LAST = WIDTH + TAP2 - 1;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] sreg;
  logic             accept;
  logic             capturing;

  always_ff @(posedge clk) begin
    if (rst) state <= st_idle;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      st_idle: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = st_shift;
      end
      st_shift: begin
        if (cnt == CW'(WIDTH - 1)) state_nxt = st_drain;
      end
      st_drain: begin
        if (cnt == CW'(LAST)) state_nxt = st_done;
      end
      st_done: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = st_idle;
      end
      default: state_nxt = st_idle;
    endcase
  end

  assign accept    = in_valid & in_ready;
  assign capturing = (state == st_shift) || (state == st_drain);
  assign sh_rst    = rst;
  assign err       = out_valid & ((res1 != word) | (res2 != word));

  // sreg holds the not-yet-sent bits; zeros shift in so the drain phase sends 0
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      sh_data <= 1'b0;
      word    <= '0;
      sreg    <= '0;
      err_cnt <= 8'd0;
    end else begin
      case (state)
        st_idle: begin
          cnt     <= '0;
          sh_data <= accept ? in_word[0] : 1'b0;
          if (accept) begin
            word <= in_word;
            sreg <= in_word >> 1;
          end
        end
        st_shift: begin
          cnt     <= cnt + 1'b1;
          sh_data <= (cnt == CW'(WIDTH - 1)) ? 1'b0 : sreg[0];
          sreg    <= sreg >> 1;
        end
        st_drain: begin
          cnt     <= cnt + 1'b1;
          sh_data <= 1'b0;
        end
        st_done: begin
          sh_data <= 1'b0;
          if (out_ready && err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
        end
        default: sh_data <= 1'b0;
      endcase
    end
  end

  // Each tap's bit k appears during cycle TAP+k, so the counter selects the slot
  always_ff @(posedge clk) begin
    if (rst) begin
      res1 <= '0;
      res2 <= '0;
    end else if (capturing) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (cnt == CW'(TAP1 + i)) res1[i] <= sh_out1;
        if (cnt == CW'(TAP2 + i)) res2[i] <= sh_out2;
      end
    end
  end

endmodule

// File: tb/tb_shifter_bist_ctrl.sv
// tb/tb_shifter_bist_ctrl.sv - directed scoreboard bench for the shifter BIST controller
module tb_shifter_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst, in_valid, out_ready;
  logic [7:0] in_word;
  logic       f1_en, f1_val, f2_en, f2_val;
  logic       in_ready, sh_data, sh_rst, sh_out1, sh_out2, raw1, raw2;
  logic       out_valid, err;
  logic [7:0] res1, res2, err_cnt;
  logic       t_in_ready, t_out_valid, t_err;
  logic [7:0] t_res1, t_res2, t_err_cnt;

  always #5 clk = ~clk;

  shifter #(.TAP1(3), .TAP2(5)) u_sh (
    .clk(clk), .rst(sh_rst), .data(sh_data), .out1(raw1), .out2(raw2)
  );

  assign sh_out1 = f1_en ? f1_val : raw1;
  assign sh_out2 = f2_en ? f2_val : raw2;

  shifter_bist_ctrl #(.WIDTH(8), .TAP1(3), .TAP2(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word), .in_ready(in_ready),
    .sh_data(sh_data), .sh_rst(sh_rst), .sh_out1(sh_out1), .sh_out2(sh_out2),
    .out_valid(out_valid), .out_ready(out_ready), .res1(res1), .res2(res2),
    .err(err), .err_cnt(err_cnt)
  );

  shifter_bist_top u_top (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word), .in_ready(t_in_ready),
    .out_valid(t_out_valid), .out_ready(out_ready), .res1(t_res1), .res2(t_res2),
    .err(t_err), .err_cnt(t_err_cnt)
  );

  typedef struct packed {
    logic [7:0] r1;
    logic [7:0] r2;
    logic       e;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   total = 0;
  int   bad = 0;
  int   exp_cnt = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [7:0] w);
    exp_t x;
    x.r1 = f1_en ? {8{f1_val}} : w;
    x.r2 = f2_en ? {8{f2_val}} : w;
    x.e  = (x.r1 != w) || (x.r2 != w);
    exp_q.push_back(x);
  endtask

  // Offers w until accepted; returns just after the accept edge with in_valid still as given by hold
  task automatic accept_word(input logic [7:0] w, input bit hold);
    int n = 0;
    in_word  = w;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("accept_ready", {31'd0, in_ready}, 32'd1);
    push_exp(w);
    tick();
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, 32'd13);
  endtask

  task automatic check_result(input string tag);
    chk({tag, "_sb_nonempty"}, {31'd0, exp_q.size() != 0}, 32'd1);
    if (exp_q.size() != 0) cur = exp_q.pop_front();
    chk({tag, "_res1"}, {24'd0, res1}, {24'd0, cur.r1});
    chk({tag, "_res2"}, {24'd0, res2}, {24'd0, cur.r2});
    chk({tag, "_err"}, {31'd0, err}, {31'd0, cur.e});
    chk({tag, "_in_ready_done"}, {31'd0, in_ready}, 32'd0);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    if (cur.e && exp_cnt < 255) exp_cnt++;
    chk({tag, "_err_cnt"}, err_cnt, exp_cnt);
    chk({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_in_ready_idle"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_word(input string tag, input logic [7:0] w);
    accept_word(w, 1'b0);
    wait_out(tag);
    check_result(tag);
    handshake(tag);
  endtask

  initial begin
    logic [7:0] s1, s2;
    logic       se;
    bit         seen;
    rst = 1'b1; in_valid = 1'b0; in_word = 8'h00; out_ready = 1'b0;
    f1_en = 1'b0; f1_val = 1'b0; f2_en = 1'b0; f2_val = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sh_data", {31'd0, sh_data}, 32'd0);
    chk("rst_sh_rst_hi", {31'd0, sh_rst}, 32'd1);
    chk("rst_res1", {24'd0, res1}, 32'd0);
    chk("rst_res2", {24'd0, res2}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    rst = 1'b0;
    #1;
    chk("sh_rst_lo", {31'd0, sh_rst}, 32'd0);
    tick();

    // Clean pass, also observed through the integration wrapper
    accept_word(8'hA5, 1'b0);
    chk("pass_sh_data_bit0", {31'd0, sh_data}, 32'd1);
    wait_out("pass");
    chk("top_out_valid", {31'd0, t_out_valid}, 32'd1);
    chk("top_res1", {24'd0, t_res1}, 32'hA5);
    chk("top_res2", {24'd0, t_res2}, 32'hA5);
    chk("top_err", {31'd0, t_err}, 32'd0);
    check_result("pass");
    handshake("pass");

    // out2 stuck at 0
    f2_en = 1'b1; f2_val = 1'b0;
    run_word("stuck", 8'hFF);
    f2_en = 1'b0;

    // Back-pressure in DONE with ignored in_valid pulses
    accept_word(8'h5A, 1'b0);
    wait_out("bp");
    s1 = res1; s2 = res2; se = err;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_word  = 8'($urandom);
      tick();
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_res1", {24'd0, res1}, {24'd0, s1});
      chk("bp_res2", {24'd0, res2}, {24'd0, s2});
      chk("bp_err", {31'd0, err}, {31'd0, se});
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    check_result("bp");
    handshake("bp");

    // Back-to-back with in_valid held high
    accept_word(8'h01, 1'b1);
    in_word = 8'h80;
    wait_out("b2b1");
    check_result("b2b1");
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("b2b_err_cnt", err_cnt, exp_cnt);
    chk("b2b_idle_after_hs", {31'd0, in_ready}, 32'd1);
    push_exp(8'h80);
    tick();
    in_valid = 1'b0;
    chk("b2b_second_accepted", {31'd0, in_ready}, 32'd0);
    wait_out("b2b2");
    check_result("b2b2");
    handshake("b2b2");

    // Reset at cnt = 4 of a word
    accept_word(8'h3C, 1'b0);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(exp_q.pop_front());
    exp_cnt = 0;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_err_cnt", {24'd0, err_cnt}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_valid", {31'd0, seen}, 32'd0);
    run_word("after_abort", 8'hC3);

    // Saturation of err_cnt
    f1_en = 1'b1; f1_val = 1'b1;
    for (int i = 0; i < 260; i++) run_word("sat", 8'h00);
    chk("sat_final", {24'd0, err_cnt}, 32'd255);
    run_word("sat_hold", 8'h00);
    chk("sat_hold_final", {24'd0, err_cnt}, 32'd255);
    f1_en = 1'b0;

    chk("top_err_cnt_clean", {24'd0, t_err_cnt}, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
